blink_decoder: RTL and testbench

//  Receiver for blink-coded LED traffic: samples an external on/off line and times marks and spaces.

---
 rtl/blink_decoder_pkg.sv | 16 +
 rtl/blink_decoder_sync.sv | 58 +++++
 rtl/blink_decoder.sv | 152 +++++++++++++++
 tb/tb_blink_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/blink_decoder_pkg.sv
// Shared types for the blink-code receiver: FSM states and element codes.
package blink_decoder_pkg;

  // ST_DROP waits out an overflowed symbol until the next inter-symbol gap.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_STUCK,
    ST_DROP
  } state_t;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

endpackage

// File: rtl/blink_decoder_sync.sv
// Blink line front end: 2-FF synchronizer, optional stability filter, rise/fall pulses.
// The filter is built only when BLINK_GLITCH_FILTER_EN is defined.
module blink_sync #(
  parameter int FILT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

`ifdef BLINK_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic [1:0] sync_q;
  logic       lvl_q, lvl_d;

  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], din};

  generate
    if (FILT_EN) begin : g_filt
      localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
      logic [FW-1:0] filt_cnt;

      // Adopt a new level only after it has differed for FILT_CYCLES straight clocks.
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          filt_cnt <= '0;
          lvl_q    <= 1'b0;
        end else if (sync_q[1] == lvl_q) begin
          filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILT_CYCLES - 1)) begin
          filt_cnt <= '0;
          lvl_q    <= sync_q[1];
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
    end else begin : g_nofilt
      assign lvl_q = sync_q[1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst)
    if (!rst) lvl_d <= 1'b0;
    else      lvl_d <= lvl_q;

  assign lvl  = lvl_q;
  assign rise = lvl_q & ~lvl_d;
  assign fall = ~lvl_q & lvl_d;

endmodule

// File: rtl/blink_decoder.sv
// Blink-coded LED receiver: times marks/spaces, builds dot/dash symbols, presents them on valid/ready.
// Define BLINK_GLITCH_FILTER_EN to reject input pulses shorter than FILT_CYCLES clocks.
module blink_decoder
  import blink_decoder_pkg::*;
#(
  parameter int CLK_HZ      = 32000000,
  parameter int TICK_HZ     = 1000,
  parameter int DOT_MAX     = 200,
  parameter int GAP_MIN     = 500,
  parameter int MARK_MAX    = 2000,
  parameter int MAX_BITS    = 8,
  parameter int FILT_CYCLES = 16,
  localparam int LEN_W      = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                blink_in,
  input  logic                sym_ready,
  output logic                sym_valid,
  output logic [MAX_BITS-1:0] sym_bits,
  output logic [LEN_W-1:0]    sym_len,
  output logic                busy,
  output logic                err_long,
  output logic                err_ovf,
  output logic                err_drop
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_TOP = (MARK_MAX + 1 > GAP_MIN) ? MARK_MAX + 1 : GAP_MIN;
  localparam int CW      = $clog2(CNT_TOP + 1);

  logic                lvl, rise, fall, edge_ev, tick;
  logic [PW-1:0]       presc;
  logic [CW-1:0]       cnt, cnt_sat;
  state_t              state, state_n;
  logic                from_space;
  logic [MAX_BITS-1:0] shreg;
  logic [LEN_W-1:0]    len;
  logic                elem, shift_en, clr, emit, long_p, ovf_p;

  blink_sync #(.FILT_CYCLES(FILT_CYCLES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (blink_in),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  // Every edge restarts the timebase; a tick landing on an edge is not counted.
  assign edge_ev = rise | fall;
  assign tick    = (presc == PW'(DIV - 1)) && !edge_ev;
  assign cnt_sat = (state == ST_MARK) ? CW'(MARK_MAX + 1) : CW'(GAP_MIN);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      presc <= '0;
      cnt   <= '0;
    end else if (edge_ev) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      if (cnt < cnt_sat) cnt <= cnt + CW'(1);
    end else begin
      presc <= presc + PW'(1);
    end

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    clr      = 1'b0;
    emit     = 1'b0;
    long_p   = 1'b0;
    ovf_p    = 1'b0;
    elem     = (cnt > CW'(DOT_MAX)) ? ELEM_DASH : ELEM_DOT;
    case (state)
      ST_IDLE:  if (rise) state_n = ST_MARK;
      ST_MARK:
        if (fall) begin
          if (cnt == '0) begin
            state_n = from_space ? ST_SPACE : ST_IDLE;
          end else if (len == LEN_W'(MAX_BITS)) begin
            ovf_p   = 1'b1;
            clr     = 1'b1;
            state_n = ST_DROP;
          end else begin
            shift_en = 1'b1;
            state_n  = ST_SPACE;
          end
        end else if (tick && cnt == CW'(MARK_MAX)) begin
          long_p  = 1'b1;
          clr     = 1'b1;
          state_n = ST_STUCK;
        end
      ST_SPACE:
        if (rise) begin
          state_n = ST_MARK;
        end else if (tick && cnt == CW'(GAP_MIN - 1)) begin
          emit    = 1'b1;
          clr     = 1'b1;
          state_n = ST_IDLE;
        end
      ST_STUCK: if (fall) state_n = ST_IDLE;
      ST_DROP:  if (tick && !lvl && cnt == CW'(GAP_MIN - 1)) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= ST_IDLE;
      from_space <= 1'b0;
      shreg      <= '0;
      len        <= '0;
    end else begin
      state <= state_n;
      // Remembered so a zero-tick mark can fall back to where it came from.
      if (rise && state != ST_MARK) from_space <= (state == ST_SPACE);
      if (clr) begin
        shreg <= '0;
        len   <= '0;
      end else if (shift_en) begin
        shreg <= shreg | (MAX_BITS'(elem) << len);
        len   <= len + LEN_W'(1);
      end
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sym_valid <= 1'b0;
      sym_bits  <= '0;
      sym_len   <= '0;
      err_long  <= 1'b0;
      err_ovf   <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      err_long <= long_p;
      err_ovf  <= ovf_p;
      err_drop <= emit && sym_valid && !sym_ready;
      if (emit && (!sym_valid || sym_ready)) begin
        sym_valid <= 1'b1;
        sym_bits  <= shreg;
        sym_len   <= len;
      end else if (sym_valid && sym_ready) begin
        sym_valid <= 1'b0;
      end
    end

endmodule

// File: tb/tb_blink_decoder.sv
// Bench for blink_decoder: directed spec scenarios plus random symbol traffic vs a segment-level model.
module tb_blink_decoder;
  localparam int CLK_HZ = 1000, TICK_HZ = 100, DOT_MAX = 3, GAP_MIN = 5;
  localparam int MARK_MAX = 20, MAX_BITS = 4, FILT_CYCLES = 16;
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int LEN_W = $clog2(MAX_BITS + 1);
`ifdef BLINK_GLITCH_FILTER_EN
  localparam int LAT = 2 + FILT_CYCLES;
`else
  localparam int LAT = 2;
`endif

  logic                clk = 1'b0, rst = 1'b0, blink_in = 1'b0, sym_ready = 1'b0;
  logic                sym_valid, busy, err_long, err_ovf, err_drop;
  logic [MAX_BITS-1:0] sym_bits;
  logic [LEN_W-1:0]    sym_len;

  blink_decoder #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DOT_MAX(DOT_MAX), .GAP_MIN(GAP_MIN),
    .MARK_MAX(MARK_MAX), .MAX_BITS(MAX_BITS), .FILT_CYCLES(FILT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .blink_in(blink_in), .sym_ready(sym_ready),
    .sym_valid(sym_valid), .sym_bits(sym_bits), .sym_len(sym_len), .busy(busy),
    .err_long(err_long), .err_ovf(err_ovf), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_long = 0, n_ovf = 0, n_drop = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
  endtask

  // Output monitor, sampled mid-cycle after inputs for the next edge have settled.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      if (sym_valid && sym_ready) got_q.push_back({1'b0, sym_len, sym_bits});
      n_long += int'(err_long);
      n_ovf  += int'(err_ovf);
      n_drop += int'(err_drop);
    end
  end

  task automatic seg(input logic v, input int cycles);
    blink_in = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: works on whole line segments; a segment of L clocks spans (L-1)/DIV ticks.
  int         m_len = 0, m_mode = 0;  // mode 0 idle, 1 collecting, 2 discarding
  logic [3:0] m_bits = '0;
  int         exp_ovf = 0;

  task automatic model_mark(input int cycles);
    int t;
    t = (cycles - 1) / DIV;
    if (t == 0 || m_mode == 2) return;
    if (m_len == MAX_BITS) begin
      exp_ovf++;
      m_mode = 2; m_len = 0; m_bits = '0;
    end else begin
      m_bits[m_len] = (t > DOT_MAX);
      m_len++;
      m_mode = 1;
    end
  endtask

  task automatic model_space(input int cycles);
    if ((cycles - 1) / DIV >= GAP_MIN) begin
      if (m_mode == 1) exp_q.push_back({1'b0, 3'(m_len), m_bits});
      m_mode = 0; m_len = 0; m_bits = '0;
    end
  endtask

  task automatic rnd_seg(input logic v, input int cycles);
    seg(v, cycles);
    if (v) model_mark(cycles);
    else   model_space(cycles);
  endtask

  initial begin
    // 1: reset state, then reset in the middle of a mark
    repeat (3) @(negedge clk);
    #1 check("rst_valid", sym_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1; sym_ready = 1'b1;
    seg(1, 20); seg(0, 20); seg(1, 30);
    #1 check("t1_busy_mark", busy, 1);
    rst = 1'b0; blink_in = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("t1_rst_outs", {sym_valid, sym_bits, sym_len, busy, err_long, err_ovf, err_drop}, 0);
    rst = 1'b1;
    seg(0, 100);
    check("t1_no_sym", got_q.size(), 0);
    check("t1_idle", busy, 0);

    // 2: dot + dash, exact emit latency
    seg(1, 20); seg(0, 20); seg(1, 60);
    blink_in = 1'b0;
    repeat (LAT + GAP_MIN * DIV) @(negedge clk);
    #1 check("t2_early", sym_valid, 0);
    @(negedge clk); #1;
    check("t2_valid", sym_valid, 1);
    check("t2_bits", sym_bits, 4'b0010);
    check("t2_len", sym_len, 2);
    @(negedge clk); #1;
    check("t2_accepted", sym_valid, 0);
    seg(0, 20);
    check("t2_count", got_q.size(), 1);
    got_q.delete();

    // 3: backpressure, second symbol dropped
    sym_ready = 1'b0; n_drop = 0;
    seg(1, 60); seg(0, 60); seg(1, 20); seg(0, 60);
    #1 check("t3_drop", n_drop, 1);
    check("t3_held_vld", sym_valid, 1);
    check("t3_held", {sym_len, sym_bits}, {3'd1, 4'b0001});
    sym_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("t3_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t3_sym", got_q[0], 8'h11);
    check("t3_cleared", sym_valid, 0);
    got_q.delete();

    // 4: stuck-on mark
    n_long = 0;
    blink_in = 1'b1;
    repeat (LAT + (MARK_MAX + 1) * DIV) @(negedge clk);
    #1 check("t4_early", err_long, 0);
    @(negedge clk); #1;
    check("t4_long", err_long, 1);
    check("t4_busy", busy, 1);
    repeat (30) @(negedge clk);
    #1 check("t4_busy_hold", busy, 1);
    repeat (250 - (LAT + (MARK_MAX + 1) * DIV + 1) - 30) @(negedge clk);
    seg(0, 100);
    #1 check("t4_idle", busy, 0);
    check("t4_long_cnt", n_long, 1);
    check("t4_no_sym", got_q.size(), 0);

    // 5: overflow on fifth element
    n_ovf = 0;
    for (int i = 0; i < MAX_BITS + 1; i++) begin
      seg(1, 20); seg(0, 20);
    end
    seg(0, 80);
    #1 check("t5_ovf", n_ovf, 1);
    check("t5_no_sym", got_q.size(), 0);
    check("t5_idle", busy, 0);

    // 6: short glitch in idle and inside a symbol
    n_long = 0; n_ovf = 0; n_drop = 0;
    seg(1, 5); seg(0, 40);
    #1 check("t6_idle", busy, 0);
    check("t6_no_sym", got_q.size(), 0);
    seg(1, 20); seg(0, 20); seg(1, 5); seg(0, 20); seg(1, 60); seg(0, 80);
    check("t6_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t6_sym", got_q[0], 8'h22);
    check("t6_errs", n_long + n_ovf + n_drop, 0);
    got_q.delete();

    // Random traffic against the model
    n_long = 0; n_ovf = 0; n_drop = 0;
    for (int s = 0; s < 20; s++) begin
      int nel;
      if ($urandom_range(0, 3) == 0) begin
        rnd_seg(1, $urandom_range(2, 10)); rnd_seg(0, $urandom_range(20, 40));
      end
      nel = $urandom_range(1, MAX_BITS + 1);
      for (int e = 0; e < nel; e++) begin
        rnd_seg(1, $urandom_range(0, 1) ? $urandom_range(21, 40) : $urandom_range(41, 200));
        if (e == nel - 1) begin
          rnd_seg(0, $urandom_range(51, 90));
        end else if ($urandom_range(0, 3) == 0) begin
          rnd_seg(0, $urandom_range(16, 20));
          rnd_seg(1, $urandom_range(2, 10));
          rnd_seg(0, $urandom_range(16, 20));
        end else begin
          rnd_seg(0, $urandom_range(16, 50));
        end
      end
    end
    seg(0, 20);
    check("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("rnd_sym%0d", i), got_q[i], exp_q[i]);
    check("rnd_ovf", n_ovf, exp_ovf);
    check("rnd_long_drop", n_long + n_drop, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
